nibble_packer: RTL and testbench
================================

NIBBLE_PACKER -- requirements
Module: nibble_packer

Interface
REQ-001 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port RESET  input  1  reset, synchronous and active-high.
REQ-003 SHALL have port NIBBLE_IN  input  4  incoming nibble.
REQ-004 SHALL have port NIBBLE_VALID  input  1  NIBBLE_IN valid this cycle.
REQ-005 SHALL have port NIBBLE_READY  output  1  packer accepts a nibble this cycle.
REQ-006 SHALL have port FLUSH  input  1  emit the partial word, zero-padded.
REQ-007 SHALL have port DATA_OUT  output  32  packed word.
REQ-008 SHALL have port DATA_COUNT  output  4  number of valid nibbles in DATA_OUT, 1..8.
REQ-009 SHALL have port DATA_MAX  output  4  largest valid nibble in DATA_OUT.
REQ-010 SHALL have port DATA_VALID  output  1  DATA_OUT/DATA_COUNT/DATA_MAX valid.
REQ-011 SHALL have port DATA_READY  input  1  consumer accepts the word.

Function
REQ-012 SHALL accept a nibble on a rising edge only when NIBBLE_VALID=1 and NIBBLE_READY=1.
REQ-013 SHALL place the k-th accepted nibble of a word (k=0..7) at DATA_OUT[4k+3:4k]; unfilled nibbles SHALL be 0.
REQ-014 SHALL keep an assembly register, a count asm_cnt (0..8) and a running maximum asm_max.
REQ-015 SHALL drive NIBBLE_READY = (asm_cnt < 8); it SHALL be combinational from registered state only.
REQ-016 SHALL compute DATA_MAX as the unsigned maximum of the valid nibbles only; padding SHALL NOT count.
REQ-017 SHALL complete a word when the 8th nibble is accepted, or when FLUSH=1 with asm_cnt>0 or a nibble accepted that cycle.
  - Accepted nibble and FLUSH in the same cycle: the nibble is included.
REQ-018 SHALL define the output as free when DATA_VALID=0 or DATA_READY=1.
REQ-019 On completion with the output free, SHALL load the word directly into the output register on the same edge and clear asm_cnt/asm_max.
  - Result: DATA_VALID=1 the cycle after the completing nibble (latency 1).
REQ-020 On completion with the output not free, SHALL hold the word in the assembly register.
  - A full word holds with asm_cnt=8 and NIBBLE_READY=0.
  - A flushed partial word SHALL be marked pending with NIBBLE_READY=0.
  - Transfer SHALL occur on the first edge the output is free.
REQ-021 SHALL hold DATA_OUT, DATA_COUNT and DATA_MAX stable while DATA_VALID=1 and DATA_READY=0.
REQ-022 SHALL clear DATA_VALID after the handshake (DATA_VALID=1, DATA_READY=1) unless a new word loads on that edge.
REQ-023 SHALL sustain back-to-back operation: a consume and a load in the same cycle SHALL give one nibble per cycle and one word per 8 cycles, with no bubble.
REQ-024 SHALL treat FLUSH with asm_cnt=0 and no accepted nibble as a no-op.
REQ-025 SHALL ignore FLUSH while a word is pending.

Reset
REQ-026 While RESET=1 at a rising edge, SHALL clear all of the following to 0: asm_cnt, asm_max, the assembly register, the pending flag, DATA_OUT, DATA_COUNT, DATA_MAX, DATA_VALID.
REQ-027 SHALL give reset priority over every handshake; a word in flight at reset is discarded.
REQ-028 SHALL drive NIBBLE_READY=1 in the first cycle after RESET deasserts.

Structure
REQ-029 SHALL take NIBBLE_W=4, NIBBLES_PER_WORD=8 and WORD_W=32 from the shared includes file, not as local literals.
REQ-030 SHALL be a single module with no sub-modules; the running max is one inline 4-bit compare.
REQ-031 SHALL use registered outputs only, except NIBBLE_READY (REQ-015).

Verification
REQ-032 Streaming: nibbles 1,2,...,8 in consecutive cycles, DATA_READY=1 -> DATA_OUT=32'h87654321, DATA_COUNT=8, DATA_MAX=8, DATA_VALID one cycle after the 8th nibble.
REQ-033 Flush: nibbles A,3,F, with FLUSH in the same cycle as F -> DATA_OUT=32'h00000F3A, DATA_COUNT=3, DATA_MAX=F.
REQ-034 Backpressure: DATA_READY=0, send 16 nibbles 0..F -> first word 32'h76543210 holds stable; second word fills, then NIBBLE_READY=0; raise DATA_READY -> 32'hFEDCBA98 is presented the next cycle.
REQ-035 Throughput: 64 continuous nibbles with DATA_READY=1 -> 8 words, NIBBLE_READY never 0, one word every 8 cycles.
REQ-036 Reset mid-word: 5 nibbles, then RESET=1 for one cycle -> DATA_VALID=0, NIBBLE_READY=1; the next 8 nibbles form a complete fresh word with DATA_COUNT=8.
REQ-037 Idle flush: FLUSH=1 with empty assembly -> DATA_VALID stays 0.

Source files
------------

// File: rtl/nibble_packer_pkg.sv
// -----------------------------------------------------------------------------
// nibble_packer_pkg
// Shared widths and types for the nibble packer.
//   NIBBLE_W         : width of one incoming nibble
//   NIBBLES_PER_WORD : nibbles packed into one output word
//   WORD_W           : packed word width
//   CNT_W            : width of a nibble count that must reach NIBBLES_PER_WORD
// word_info_t bundles a word with its valid-nibble count and largest nibble so
// the assembly register and the output register share one shape.
// -----------------------------------------------------------------------------
package nibble_packer_pkg;

    localparam int NIBBLE_W         = 4;
    localparam int NIBBLES_PER_WORD = 8;
    localparam int WORD_W           = NIBBLE_W * NIBBLES_PER_WORD;
    localparam int CNT_W            = $clog2(NIBBLES_PER_WORD + 1);

    typedef logic [NIBBLE_W-1:0] nibble_t;
    typedef logic [WORD_W-1:0]   word_t;
    typedef logic [CNT_W-1:0]    cnt_t;

    typedef struct packed {
        word_t   data;
        cnt_t    count;
        nibble_t max;
    } word_info_t;

endpackage

// File: rtl/nibble_packer.sv
// -----------------------------------------------------------------------------
// nibble_packer
// Packs a stream of nibbles into words, nibble k of a word landing at bits
// [4k+3:4k]. A word is emitted when full, or early (zero-padded) on FLUSH.
// Each emitted word carries the number of valid nibbles and the largest one.
//
// Ports
//   CLK          in   clock, all state on the rising edge
//   RESET        in   synchronous, active-high reset
//   NIBBLE_IN    in   incoming nibble
//   NIBBLE_VALID in   NIBBLE_IN is valid this cycle
//   NIBBLE_READY out  packer accepts a nibble this cycle (from state only)
//   FLUSH        in   emit the partial word, zero-padded
//   DATA_OUT     out  packed word
//   DATA_COUNT   out  valid nibbles in DATA_OUT (1..8)
//   DATA_MAX     out  largest valid nibble in DATA_OUT
//   DATA_VALID   out  DATA_OUT/DATA_COUNT/DATA_MAX are valid
//   DATA_READY   in   consumer accepts the word
// -----------------------------------------------------------------------------
module nibble_packer
    import nibble_packer_pkg::*;
(
    input  logic                CLK,
    input  logic                RESET,
    input  logic [NIBBLE_W-1:0] NIBBLE_IN,
    input  logic                NIBBLE_VALID,
    output logic                NIBBLE_READY,
    input  logic                FLUSH,
    output logic [WORD_W-1:0]   DATA_OUT,
    output logic [CNT_W-1:0]    DATA_COUNT,
    output logic [NIBBLE_W-1:0] DATA_MAX,
    output logic                DATA_VALID,
    input  logic                DATA_READY
);

    word_info_t asm_q,   asm_d;    // word under assembly (or held complete)
    logic       pend_q,  pend_d;   // flushed partial word waiting for output
    word_info_t out_q,   out_d;    // presented word
    logic       valid_q, valid_d;

    word_info_t grown;             // assembly including this cycle's nibble
    logic       accept;
    logic       out_free;
    logic       complete;

    // A held full word shows up as count == NIBBLES_PER_WORD; a held partial
    // word is flagged by pend_q. Either way no more nibbles are taken.
    assign NIBBLE_READY = (asm_q.count < CNT_W'(NIBBLES_PER_WORD)) && !pend_q;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        accept   = NIBBLE_VALID && NIBBLE_READY;
        out_free = !valid_q || DATA_READY;

        grown = asm_q;
        if (accept) begin
            for (int k = 0; k < NIBBLES_PER_WORD; k++) begin
                if (asm_q.count == CNT_W'(k)) begin
                    grown.data[k*NIBBLE_W +: NIBBLE_W] = NIBBLE_IN;
                end
            end
            grown.count = asm_q.count + CNT_W'(1);
            if (NIBBLE_IN > asm_q.max) begin
                grown.max = NIBBLE_IN;
            end
        end

        // A nibble arriving with FLUSH is part of the flushed word; an empty
        // flush is a no-op. A pending word stays complete until it moves.
        complete = pend_q
                || (grown.count == CNT_W'(NIBBLES_PER_WORD))
                || (FLUSH && (grown.count != '0));

        asm_d   = grown;
        pend_d  = pend_q;
        out_d   = out_q;
        valid_d = valid_q;

        if (complete && out_free) begin
            // Direct load: consume of the old word and load of the new one
            // can share an edge, giving back-to-back words with no bubble.
            out_d   = grown;
            valid_d = 1'b1;
            asm_d   = '0;
            pend_d  = 1'b0;
        end else begin
            if (complete) begin
                pend_d = (grown.count != CNT_W'(NIBBLES_PER_WORD));
            end
            if (valid_q && DATA_READY) begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        // NOTE: state uses non-blocking assignments so every register samples
        // the pre-edge values, independent of statement order.
        if (RESET) begin
            asm_q   <= '0;
            pend_q  <= 1'b0;
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            asm_q   <= asm_d;
            pend_q  <= pend_d;
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign DATA_OUT   = out_q.data;
    assign DATA_COUNT = out_q.count;
    assign DATA_MAX   = out_q.max;
    assign DATA_VALID = valid_q;

endmodule

// File: tb/tb_nibble_packer.sv
// -----------------------------------------------------------------------------
// tb_nibble_packer
// Directed bench for nibble_packer. A queue-based model of the packer is
// compared against the DUT on every falling edge; directed scenarios add
// hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_nibble_packer;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [3:0]  NIBBLE_IN = 4'h0;
    logic        NIBBLE_VALID = 1'b0;
    logic        NIBBLE_READY;
    logic        FLUSH = 1'b0;
    logic [31:0] DATA_OUT;
    logic [3:0]  DATA_COUNT;
    logic [3:0]  DATA_MAX;
    logic        DATA_VALID;
    logic        DATA_READY = 1'b0;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    nibble_packer dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .NIBBLE_IN    (NIBBLE_IN),
        .NIBBLE_VALID (NIBBLE_VALID),
        .NIBBLE_READY (NIBBLE_READY),
        .FLUSH        (FLUSH),
        .DATA_OUT     (DATA_OUT),
        .DATA_COUNT   (DATA_COUNT),
        .DATA_MAX     (DATA_MAX),
        .DATA_VALID   (DATA_VALID),
        .DATA_READY   (DATA_READY)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          q[$];        // nibbles of the word being assembled
    bit          held;        // a complete word waits for the output
    bit          m_valid;
    logic [31:0] m_data;
    int          m_count;
    int          m_max;
    bit          m_rdy, m_comp, m_free;

    always @(posedge CLK) begin
        if (RESET) begin
            q.delete();
            held    = 1'b0;
            m_valid = 1'b0;
            m_data  = '0;
            m_count = 0;
            m_max   = 0;
        end else begin
            m_rdy = (q.size() < 8) && !held;
            if (NIBBLE_VALID && m_rdy) q.push_back(int'(NIBBLE_IN));
            m_comp = held || (q.size() == 8) || (FLUSH && q.size() > 0);
            m_free = !m_valid || DATA_READY;
            if (m_comp && m_free) begin
                m_data = '0;
                m_max  = 0;
                foreach (q[i]) begin
                    m_data = m_data | (32'(q[i]) << (4 * i));
                    if (q[i] > m_max) m_max = q[i];
                end
                m_count = q.size();
                m_valid = 1'b1;
                q.delete();
                held = 1'b0;
            end else begin
                if (m_comp) held = 1'b1;
                if (m_valid && DATA_READY) m_valid = 1'b0;
            end
        end
    end

    always @(negedge CLK) begin
        if (cmp_en) begin
            check("model_ready", NIBBLE_READY, (q.size() < 8) && !held);
            check("model_valid", DATA_VALID, m_valid);
            if (m_valid) begin
                check("model_data",  DATA_OUT,   m_data);
                check("model_count", DATA_COUNT, m_count);
                check("model_max",   DATA_MAX,   m_max);
            end
        end
    end

    // Drive one cycle of inputs; returns 2 time units after the sampling edge.
    task automatic cycle(input bit v, input logic [3:0] n, input bit f,
                         input bit r, input bit rst = 1'b0);
        NIBBLE_VALID = v;
        NIBBLE_IN    = n;
        FLUSH        = f;
        DATA_READY   = r;
        RESET        = rst;
        @(posedge CLK);
        #2;
    endtask

    int words, stalls, misplaced;
    logic [3:0] fresh [8];

    initial begin
        // ---- reset ----
        cycle(0, 4'h0, 0, 0, 1);
        cmp_en = 1'b1;
        cycle(0, 4'h0, 0, 0, 1);
        check("reset_valid", DATA_VALID, 0);
        check("reset_ready", NIBBLE_READY, 1);
        check("reset_data",  DATA_OUT, 0);
        check("reset_count", DATA_COUNT, 0);
        check("reset_max",   DATA_MAX, 0);

        // ---- streaming 1..8 ----
        for (int i = 1; i <= 8; i++) begin
            cycle(1, 4'(i), 0, 1);
            if (i < 8) check("stream_early_valid", DATA_VALID, 0);
        end
        check("stream_valid", DATA_VALID, 1);
        check("stream_data",  DATA_OUT, 32'h87654321);
        check("stream_count", DATA_COUNT, 8);
        check("stream_max",   DATA_MAX, 8);
        cycle(0, 4'h0, 0, 1);
        check("stream_drain", DATA_VALID, 0);

        // ---- flush with nibble in the same cycle ----
        cycle(1, 4'hA, 0, 1);
        cycle(1, 4'h3, 0, 1);
        cycle(1, 4'hF, 1, 1);
        check("flush_valid", DATA_VALID, 1);
        check("flush_data",  DATA_OUT, 32'h00000F3A);
        check("flush_count", DATA_COUNT, 3);
        check("flush_max",   DATA_MAX, 4'hF);
        cycle(0, 4'h0, 0, 1);

        // ---- backpressure: 16 nibbles with DATA_READY low ----
        for (int i = 0; i < 16; i++) begin
            cycle(1, 4'(i), 0, 0);
            if (i == 7) check("bp_first_data", DATA_OUT, 32'h76543210);
        end
        check("bp_hold_data",  DATA_OUT, 32'h76543210);
        check("bp_hold_max",   DATA_MAX, 7);
        check("bp_hold_ready", NIBBLE_READY, 0);
        cycle(0, 4'h0, 0, 1);
        check("bp_second_valid", DATA_VALID, 1);
        check("bp_second_data",  DATA_OUT, 32'hFEDCBA98);
        check("bp_second_count", DATA_COUNT, 8);
        check("bp_second_max",   DATA_MAX, 4'hF);
        check("bp_ready_back",   NIBBLE_READY, 1);
        cycle(0, 4'h0, 0, 1);
        check("bp_drain", DATA_VALID, 0);

        // ---- throughput: 64 continuous nibbles ----
        words = 0; stalls = 0; misplaced = 0;
        for (int i = 0; i < 64; i++) begin
            cycle(1, 4'((i * 5 + 3) % 16), 0, 1);
            if (!NIBBLE_READY) stalls++;
            if (DATA_VALID) words++;
            if (DATA_VALID != ((i % 8) == 7)) misplaced++;
        end
        check("tp_words",     words, 8);
        check("tp_stalls",    stalls, 0);
        check("tp_misplaced", misplaced, 0);
        cycle(0, 4'h0, 0, 1);

        // ---- reset mid-word ----
        for (int i = 0; i < 5; i++) cycle(1, 4'(i + 1), 0, 1);
        cycle(0, 4'h0, 0, 1, 1);
        check("rst_mid_valid", DATA_VALID, 0);
        check("rst_mid_ready", NIBBLE_READY, 1);
        fresh = '{4'hC, 4'h0, 4'hF, 4'h0, 4'h1, 4'h2, 4'h3, 4'h4};
        for (int k = 0; k < 8; k++) cycle(1, fresh[k], 0, 1);
        check("rst_fresh_valid", DATA_VALID, 1);
        check("rst_fresh_data",  DATA_OUT, 32'h43210F0C);
        check("rst_fresh_count", DATA_COUNT, 8);
        check("rst_fresh_max",   DATA_MAX, 4'hF);

        // ---- flushed partial word pending behind a held output ----
        cycle(1, 4'h5, 0, 0);
        cycle(1, 4'h6, 1, 0);
        check("pend_ready",     NIBBLE_READY, 0);
        check("pend_hold_data", DATA_OUT, 32'h43210F0C);
        cycle(1, 4'h7, 1, 0);
        check("pend_ignore_ready", NIBBLE_READY, 0);
        cycle(0, 4'h0, 0, 1);
        check("pend_data",  DATA_OUT, 32'h00000065);
        check("pend_count", DATA_COUNT, 2);
        check("pend_max",   DATA_MAX, 6);
        cycle(0, 4'h0, 0, 1);
        check("pend_drain", DATA_VALID, 0);
        check("pend_ready_back", NIBBLE_READY, 1);

        // ---- idle flush ----
        cycle(0, 4'h0, 1, 1);
        check("idle_flush_valid", DATA_VALID, 0);
        cycle(0, 4'h0, 0, 1);
        check("idle_flush_after", DATA_VALID, 0);

        @(negedge CLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
